// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with valid/ready handshake, optional 2-entry skid buffer,
// synchronous flush with a saturating discarded-entry counter, and immediate extension.
module if_id_skid_reg #(
    parameter int                DATA_W = 32,
    parameter int                PC_W   = 32,
    parameter int                IMM_W  = 16,
    parameter int                SKID   = 1,
    parameter logic [DATA_W-1:0] NOP    = '0,
    parameter int                CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [PC_W-1:0]   in_pc,
    input  logic              flush,
    input  logic              imm_zext,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_imm,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKIDF = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t              r_state;
    logic                r_in_ready;
    logic [DATA_W-1:0]   r_main_instr;
    logic [PC_W-1:0]     r_main_pc;
    logic [DATA_W-1:0]   r_skid_instr;
    logic [PC_W-1:0]     r_skid_pc;
    logic [CNT_W-1:0]    r_flush_cnt;

    state_t              w_next_state;
    logic                w_in_ready;
    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_clear_main;
    logic                w_load_skid;
    logic [1:0]          w_held;
    logic [CNT_W:0]      w_cnt_sum;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [IMM_W-1:0]    w_imm;

    // Skid build breaks the out_ready -> in_ready path; the single-entry build keeps it.
    assign w_in_ready = (SKID != 0) ? r_in_ready : (!out_valid || out_ready);
    assign in_ready   = w_in_ready;
    assign out_valid  = (r_state != ST_EMPTY);
    assign w_in_fire  = in_valid && w_in_ready;
    assign w_out_fire = out_valid && out_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_state     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_clear_main     = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    w_next_state   = ST_FULL;
                    w_load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire && (SKID != 0)) begin
                    w_next_state = ST_SKIDF;
                    w_load_skid  = 1'b1;
                end else if (w_out_fire) begin
                    w_next_state = ST_EMPTY;
                    w_clear_main = 1'b1;
                end
            end
            ST_SKIDF: begin
                if (w_out_fire) begin
                    w_next_state     = ST_FULL;
                    w_load_main_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
                w_clear_main = 1'b1;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_main_instr <= NOP;
            r_main_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_state      <= ST_EMPTY;
            r_in_ready   <= 1'b1;
            r_main_instr <= NOP;
            r_main_pc    <= '0;
            r_skid_instr <= '0;
            r_skid_pc    <= '0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state != ST_SKIDF);
            if (w_load_main_in) begin
                r_main_instr <= in_instr;
                r_main_pc    <= in_pc;
            end else if (w_load_main_skid) begin
                r_main_instr <= r_skid_instr;
                r_main_pc    <= r_skid_pc;
            end else if (w_clear_main) begin
                r_main_instr <= NOP;
                r_main_pc    <= '0;
            end
            if (w_load_skid) begin
                r_skid_instr <= in_instr;
                r_skid_pc    <= in_pc;
            end
        end
    end

    // Discarded entries on a flush: everything held plus anything accepted that same cycle.
    always_comb begin
        case (r_state)
            ST_FULL:  w_held = 2'd1;
            ST_SKIDF: w_held = 2'd2;
            default:  w_held = 2'd0;
        endcase
        w_cnt_sum  = {1'b0, r_flush_cnt}
                   + {{(CNT_W-1){1'b0}}, w_held}
                   + {{CNT_W{1'b0}}, w_in_fire};
        w_cnt_next = w_cnt_sum[CNT_W] ? CNT_MAX : w_cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if (flush) begin
            r_flush_cnt <= w_cnt_next;
        end
    end

    assign flush_cnt = r_flush_cnt;
    assign out_instr = r_main_instr;
    assign out_pc    = r_main_pc;
    assign w_imm     = r_main_instr[IMM_W-1:0];
    assign out_imm   = imm_zext ? {{(DATA_W-IMM_W){1'b0}}, w_imm}
                                : {{(DATA_W-IMM_W){w_imm[IMM_W-1]}}, w_imm};

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg: a skid-buffer instance and a single-entry instance
// side by side, with hand-computed expectations checked after each clock edge.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst;

    logic        a_in_valid, a_in_ready, a_flush, a_imm_zext, a_out_valid, a_out_ready;
    logic [31:0] a_in_instr, a_in_pc, a_out_instr, a_out_pc, a_out_imm;
    logic [7:0]  a_flush_cnt;

    logic        b_in_valid, b_in_ready, b_flush, b_imm_zext, b_out_valid, b_out_ready;
    logic [31:0] b_in_instr, b_in_pc, b_out_instr, b_out_pc, b_out_imm;
    logic [7:0]  b_flush_cnt;

    int checks   = 0;
    int failures = 0;
    int exp_cnt;

    always #5 clk = ~clk;

    if_id_skid_reg #(.SKID(1)) u_skid (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_instr(a_in_instr), .in_pc(a_in_pc),
        .flush(a_flush), .imm_zext(a_imm_zext),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_instr(a_out_instr),
        .out_pc(a_out_pc), .out_imm(a_out_imm), .flush_cnt(a_flush_cnt)
    );

    if_id_skid_reg #(.SKID(0)) u_noskid (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr), .in_pc(b_in_pc),
        .flush(b_flush), .imm_zext(b_imm_zext),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_instr(b_out_instr),
        .out_pc(b_out_pc), .out_imm(b_out_imm), .flush_cnt(b_flush_cnt)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h2001_0005; a_in_pc = 32'h0;
        a_flush = 1'b0; a_imm_zext = 1'b0; a_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_instr = 32'h2001_0005; b_in_pc = 32'h0;
        b_flush = 1'b0; b_imm_zext = 1'b0; b_out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted
        step(); step();
        check("rst_a_valid", 32'(a_out_valid), 32'h0);
        check("rst_a_instr", a_out_instr, 32'h0);
        check("rst_a_pc", a_out_pc, 32'h0);
        check("rst_a_cnt", 32'(a_flush_cnt), 32'h0);
        check("rst_a_ready", 32'(a_in_ready), 32'h1);
        check("rst_a_imm", a_out_imm, 32'h0);
        check("rst_b_valid", 32'(b_out_valid), 32'h0);
        check("rst_b_ready", 32'(b_in_ready), 32'h1);
        a_in_valid = 1'b0; b_in_valid = 1'b0;
        rst = 1'b1;
        step();
        check("idle_a_valid", 32'(a_out_valid), 32'h0);

        // Back-to-back stream, 1-cycle latency, order kept
        a_out_ready = 1'b1;
        a_in_valid = 1'b1; a_in_instr = 32'h2001_0005; a_in_pc = 32'h0;
        step();
        check("s0_valid", 32'(a_out_valid), 32'h1);
        check("s0_instr", a_out_instr, 32'h2001_0005);
        check("s0_pc", a_out_pc, 32'h0);
        check("s0_ready", 32'(a_in_ready), 32'h1);
        a_in_instr = 32'h2001_0006; a_in_pc = 32'h4;
        step();
        check("s1_valid", 32'(a_out_valid), 32'h1);
        check("s1_instr", a_out_instr, 32'h2001_0006);
        check("s1_pc", a_out_pc, 32'h4);
        a_in_valid = 1'b0;
        step();
        check("s2_valid", 32'(a_out_valid), 32'h0);
        check("s2_instr", a_out_instr, 32'h0);
        check("s2_pc", a_out_pc, 32'h0);

        // Stall fills main then skid; C is held off until space frees up
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h1111_1111; a_in_pc = 32'h10;
        step();
        check("st_a_instr", a_out_instr, 32'h1111_1111);
        check("st_a_ready", 32'(a_in_ready), 32'h1);
        a_in_instr = 32'h2222_2222; a_in_pc = 32'h14;
        step();
        check("st_b_ready", 32'(a_in_ready), 32'h0);
        check("st_b_instr", a_out_instr, 32'h1111_1111);
        check("st_b_pc", a_out_pc, 32'h10);
        a_in_instr = 32'h3333_3333; a_in_pc = 32'h18;
        step();
        check("st_c_ready", 32'(a_in_ready), 32'h0);
        check("st_c_instr", a_out_instr, 32'h1111_1111);
        check("st_c_valid", 32'(a_out_valid), 32'h1);
        a_out_ready = 1'b1;
        step();
        check("rel_b_instr", a_out_instr, 32'h2222_2222);
        check("rel_b_pc", a_out_pc, 32'h14);
        check("rel_b_ready", 32'(a_in_ready), 32'h1);
        step();
        check("rel_c_instr", a_out_instr, 32'h3333_3333);
        check("rel_c_pc", a_out_pc, 32'h18);
        a_in_valid = 1'b0;
        step();
        check("rel_empty", 32'(a_out_valid), 32'h0);
        check("pre_flush_cnt", 32'(a_flush_cnt), 32'h0);

        // Flush: one held + in_fire -> +2, incoming entry dropped
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h4444_4444; a_in_pc = 32'h20;
        step();
        a_in_instr = 32'h5555_5555; a_in_pc = 32'h24; a_flush = 1'b1;
        step();
        check("fl1_valid", 32'(a_out_valid), 32'h0);
        check("fl1_instr", a_out_instr, 32'h0);
        check("fl1_pc", a_out_pc, 32'h0);
        check("fl1_ready", 32'(a_in_ready), 32'h1);
        check("fl1_cnt", 32'(a_flush_cnt), 32'd2);
        a_flush = 1'b0; a_in_valid = 1'b0;
        step();
        check("fl1_dropped", 32'(a_out_valid), 32'h0);

        // Flush with both entries held (in_ready low, so no in_fire) -> +2
        a_in_valid = 1'b1; a_in_instr = 32'h4444_4444; a_in_pc = 32'h20;
        step();
        a_in_instr = 32'h5555_5555; a_in_pc = 32'h24;
        step();
        check("fl2_preready", 32'(a_in_ready), 32'h0);
        a_flush = 1'b1;
        step();
        check("fl2_cnt", 32'(a_flush_cnt), 32'd4);
        check("fl2_ready", 32'(a_in_ready), 32'h1);
        check("fl2_valid", 32'(a_out_valid), 32'h0);
        a_flush = 1'b0;

        // Flush with one held and no incoming -> +1
        a_in_instr = 32'h6666_6666; a_in_pc = 32'h28;
        step();
        a_in_valid = 1'b0; a_flush = 1'b1;
        step();
        check("fl3_cnt", 32'(a_flush_cnt), 32'd5);
        a_flush = 1'b0;

        // Repeat +2 flushes: 5 + 2*125 = 255, then must stick at 255 rather than wrap
        exp_cnt = 5;
        for (int i = 0; i < 127; i++) begin
            a_in_valid = 1'b1; a_flush = 1'b0;
            step();
            a_flush = 1'b1;
            step();
            exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
            check("sat_cnt", 32'(a_flush_cnt), 32'(exp_cnt));
        end
        a_flush = 1'b0; a_in_valid = 1'b0;
        step();
        check("sat_final", 32'(a_flush_cnt), 32'd255);

        // Immediate extension of the held instruction
        a_imm_zext = 1'b0;
        a_in_valid = 1'b1; a_in_instr = 32'h2001_FFFC; a_in_pc = 32'h40;
        step();
        a_in_valid = 1'b0;
        check("imm_sext", a_out_imm, 32'hFFFF_FFFC);
        a_imm_zext = 1'b1;
        #1;
        check("imm_zext", a_out_imm, 32'h0000_FFFC);
        a_in_valid = 1'b1; a_in_instr = 32'h2001_7FF0;
        a_out_ready = 1'b1; a_imm_zext = 1'b0;
        step();
        a_in_valid = 1'b0;
        check("imm_pos_sext", a_out_imm, 32'h0000_7FF0);
        step();
        check("imm_empty", a_out_imm, 32'h0);

        // Single-entry build: combinational in_ready follows out_ready while full
        b_out_ready = 1'b0;
        b_in_valid = 1'b1; b_in_instr = 32'h7777_7777; b_in_pc = 32'h50;
        step();
        check("ns_valid", 32'(b_out_valid), 32'h1);
        check("ns_ready_stall", 32'(b_in_ready), 32'h0);
        check("ns_instr", b_out_instr, 32'h7777_7777);
        b_in_instr = 32'h8888_8888; b_in_pc = 32'h54;
        step();
        check("ns_hold_instr", b_out_instr, 32'h7777_7777);
        check("ns_hold_pc", b_out_pc, 32'h50);
        b_out_ready = 1'b1;
        #1;
        check("ns_ready_comb", 32'(b_in_ready), 32'h1);
        step();
        check("ns_next_instr", b_out_instr, 32'h8888_8888);
        check("ns_next_pc", b_out_pc, 32'h54);
        check("ns_next_valid", 32'(b_out_valid), 32'h1);
        b_in_valid = 1'b0;
        step();
        check("ns_empty", 32'(b_out_valid), 32'h0);
        check("ns_cnt", 32'(b_flush_cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
